// File: rtl/spi_ctrl_pos.sv
// ---------------------------------------------------------------------------
// spi_ctrl_pos
// SPI master in mode 0, MSB first. Each accepted request sends one byte:
// cs goes low, eight sclk periods are generated from the system clock by a
// half-period divider, and cs goes high again once a hold interval has passed.
//
// Optional feature macro: SPI_CTRL_OVR_ERR_EN
//   defined   -> a tx_start seen while busy sets the sticky ovr_err flag
//   undefined -> ovr_err is tied low
//
// Parameters
//   CLK_DIV   system clocks per sclk half-period (1..255)
// Ports
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_dat    byte to send, latched when a request is accepted
//   tx_start  request strobe, level-sampled each clk
//   sclk      SPI clock, idle low
//   mosi      serial data, changes only while sclk is low
//   cs        chip select, active low
//   busy      high from acceptance until cs returns high
//   done      one-cycle pulse at the end of a frame
//   ovr_err   sticky overrun flag
// ---------------------------------------------------------------------------
module spi_ctrl_pos #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_start,
    output logic       sclk,
    output logic       mosi,
    output logic       cs,
    output logic       busy,
    output logic       done,
    output logic       ovr_err
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HI,
        SCLK_LO,
        HOLD
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     r_state;
    state_t     w_stateNext;
    logic [7:0] r_divCnt;
    logic [7:0] r_shift;
    logic [7:0] w_shiftNext;
    logic [2:0] r_bitCnt;
    logic [2:0] w_bitCntNext;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_cs;
    logic       r_busy;
    logic       r_done;
    logic       w_sclkNext;
    logic       w_mosiNext;
    logic       w_csNext;
    logic       w_busyNext;
    logic       w_doneNext;
    logic       w_divEnd;

    assign w_divEnd = (r_divCnt == DIV_LAST);

    // State and every registered output update together so all SPI pins
    // come straight from flops. The divider restarts on every state change,
    // which happens exactly when it reaches its last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_divCnt <= '0;
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_cs     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_divCnt <= (r_state == IDLE || w_divEnd) ? 8'd0 : r_divCnt + 8'd1;
            r_shift  <= w_shiftNext;
            r_bitCnt <= w_bitCntNext;
            r_sclk   <= w_sclkNext;
            r_mosi   <= w_mosiNext;
            r_cs     <= w_csNext;
            r_busy   <= w_busyNext;
            r_done   <= w_doneNext;
        end
    end

    // Next-state logic: each non-idle state lasts one divider period.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (tx_start) w_stateNext = SETUP;
            SETUP:   if (w_divEnd) w_stateNext = SCLK_HI;
            SCLK_HI: if (w_divEnd) w_stateNext = (r_bitCnt == 3'd7) ? HOLD : SCLK_LO;
            SCLK_LO: if (w_divEnd) w_stateNext = SCLK_HI;
            HOLD:    if (w_divEnd) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs. The next bit is
    // taken from r_shift[6] on the falling edge so it appears together with
    // the shift, keeping mosi stable for the whole high phase of sclk.
    always_comb begin
        w_shiftNext  = r_shift;
        w_bitCntNext = r_bitCnt;
        w_sclkNext   = r_sclk;
        w_mosiNext   = r_mosi;
        w_csNext     = r_cs;
        w_busyNext   = r_busy;
        w_doneNext   = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_start) begin
                    w_shiftNext  = tx_dat;
                    w_bitCntNext = 3'd0;
                    w_mosiNext   = tx_dat[7];
                    w_csNext     = 1'b0;
                    w_busyNext   = 1'b1;
                end
            end
            SETUP, SCLK_LO: begin
                if (w_divEnd) w_sclkNext = 1'b1;
            end
            SCLK_HI: begin
                if (w_divEnd) begin
                    w_sclkNext = 1'b0;
                    if (r_bitCnt != 3'd7) begin
                        w_shiftNext  = {r_shift[6:0], 1'b0};
                        w_mosiNext   = r_shift[6];
                        w_bitCntNext = r_bitCnt + 3'd1;
                    end
                end
            end
            HOLD: begin
                if (w_divEnd) begin
                    w_csNext     = 1'b1;
                    w_busyNext   = 1'b0;
                    w_doneNext   = 1'b1;
                    w_mosiNext   = 1'b0;
                    w_bitCntNext = 3'd0;
                end
            end
            default: ;
        endcase
    end

`ifdef SPI_CTRL_OVR_ERR_EN
    logic r_ovrErr;

    // A request arriving while a frame is in flight is dropped; remember it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovrErr <= 1'b0;
        else if (tx_start && r_busy) r_ovrErr <= 1'b1;
    end

    assign ovr_err = r_ovrErr;
`else
    assign ovr_err = 1'b0;
`endif

    assign sclk = r_sclk;
    assign mosi = r_mosi;
    assign cs   = r_cs;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_spi_ctrl_pos.sv
// ---------------------------------------------------------------------------
// tb_spi_ctrl_pos
// Drives two controllers (CLK_DIV=4 and CLK_DIV=1) from one clock and reset.
// A small receiver model per instance shifts mosi in on each rising sclk
// while cs is low. Frames are described by a table of records; each record
// says which instance to use, the byte, optional mid-frame events and the
// expected results.
// ---------------------------------------------------------------------------
module tb_spi_ctrl_pos;

    typedef struct {
        int         sel;
        logic [7:0] dat;
        int         injCycle;
        logic [7:0] injDat;
        int         rstCycle;
        int         tail;
        logic [7:0] expRx;
        int         expDone;
        int         expEdges;
    } vec_t;

    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] txDat4 = 8'h00;
    logic       txStart4 = 1'b0;
    logic [7:0] txDat1 = 8'h00;
    logic       txStart1 = 1'b0;
    logic       sclk4, mosi4, cs4, busy4, done4, ovr4;
    logic       sclk1, mosi1, cs1, busy1, done1, ovr1;

    logic [7:0] rx4 = 8'h00;
    logic [7:0] rx1 = 8'h00;
    int         cnt4 = 0;
    int         cnt1 = 0;

    int checks = 0;
    int errors = 0;
    int curSel = 4;
    int ovrEnabled;
    int ovrModel4 = 0;
    vec_t vecs [NV];

    logic       mSclk, mMosi, mCs, mBusy, mDone, mOvr;
    logic [7:0] mRx;
    int         mCnt;

    assign mSclk = (curSel == 1) ? sclk1 : sclk4;
    assign mMosi = (curSel == 1) ? mosi1 : mosi4;
    assign mCs   = (curSel == 1) ? cs1   : cs4;
    assign mBusy = (curSel == 1) ? busy1 : busy4;
    assign mDone = (curSel == 1) ? done1 : done4;
    assign mOvr  = (curSel == 1) ? ovr1  : ovr4;
    assign mRx   = (curSel == 1) ? rx1   : rx4;
    assign mCnt  = (curSel == 1) ? cnt1  : cnt4;

    spi_ctrl_pos #(.CLK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .tx_dat(txDat4), .tx_start(txStart4),
        .sclk(sclk4), .mosi(mosi4), .cs(cs4), .busy(busy4), .done(done4),
        .ovr_err(ovr4)
    );

    spi_ctrl_pos #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .tx_dat(txDat1), .tx_start(txStart1),
        .sclk(sclk1), .mosi(mosi1), .cs(cs1), .busy(busy1), .done(done1),
        .ovr_err(ovr1)
    );

    always #5 clk = ~clk;

    // Receiver models: clear when cs falls, shift on each rising sclk.
    always @(posedge sclk4 or negedge cs4) begin
        if (!cs4 && sclk4) begin
            rx4  = {rx4[6:0], mosi4};
            cnt4 = cnt4 + 1;
        end else if (!cs4) begin
            rx4  = 8'h00;
            cnt4 = 0;
        end
    end

    always @(posedge sclk1 or negedge cs1) begin
        if (!cs1 && sclk1) begin
            rx1  = {rx1[6:0], mosi1};
            cnt1 = cnt1 + 1;
        end else if (!cs1) begin
            rx1  = 8'h00;
            cnt1 = 0;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic setIn(input logic start, input logic [7:0] dat);
        if (curSel == 1) begin
            txStart1 = start;
            txDat1   = dat;
        end else begin
            txStart4 = start;
            txDat4   = dat;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " cs"},      int'(mCs),   1);
        checkOutput({tag, " sclk"},    int'(mSclk), 0);
        checkOutput({tag, " mosi"},    int'(mMosi), 0);
        checkOutput({tag, " busy"},    int'(mBusy), 0);
        checkOutput({tag, " done"},    int'(mDone), 0);
        checkOutput({tag, " ovr_err"}, int'(mOvr),  0);
    endtask

    // Called away from a clock edge; the request is sampled at the next edge.
    task automatic applyStimulus(input vec_t v);
        int   cyc;
        int   doneCyc;
        int   badFrame;
        int   violations;
        int   badTail;
        logic prevSclk;
        logic prevMosi;
        curSel = v.sel;
        #0;
        setIn(1'b1, v.dat);
        @(posedge clk); #1;
        cyc = 1;
        setIn(1'b0, ~v.dat);
        checkOutput("start cs", int'(mCs), 0);
        checkOutput("start busy", int'(mBusy), 1);
        checkOutput("start mosi msb", int'(mMosi), int'(v.dat[7]));
        doneCyc    = 0;
        badFrame   = 0;
        violations = 0;
        prevSclk   = mSclk;
        prevMosi   = mMosi;
        while (doneCyc == 0 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == v.injCycle) begin
                setIn(1'b1, v.injDat);
                if (ovrEnabled != 0) ovrModel4 = 1;
            end else if (cyc == v.injCycle + 1) begin
                setIn(1'b0, ~v.dat);
            end
            if (cyc == v.rstCycle) begin
                rst = 1'b1;
                #1;
                ovrModel4 = 0;
                checkResetOutputs("mid-frame reset");
                checkOutput("edges before reset", mCnt, v.expEdges);
                #2 rst = 1'b0;
                break;
            end
            if (prevSclk && mSclk && (mMosi != prevMosi)) violations++;
            prevSclk = mSclk;
            prevMosi = mMosi;
            if (mDone) doneCyc = cyc;
            else if (mCs || !mBusy) badFrame++;
        end
        if (v.rstCycle == 0) begin
            checkOutput("done cycle", doneCyc, v.expDone);
            checkOutput("cs high at done", int'(mCs), 1);
            checkOutput("busy low at done", int'(mBusy), 0);
            checkOutput("mosi low at done", int'(mMosi), 0);
            checkOutput("cs/busy held in frame", badFrame, 0);
            checkOutput("mosi moved with sclk high", violations, 0);
            checkOutput("rising edges", mCnt, v.expEdges);
            checkOutput("received byte", int'(mRx), int'(v.expRx));
            checkOutput("ovr_err", int'(mOvr), (v.sel == 1) ? 0 : ovrModel4);
        end
        badTail = 0;
        for (int i = 0; i < v.tail; i++) begin
            @(posedge clk); #1;
            if (!mCs || mBusy || mDone || mSclk) badTail++;
        end
        if (v.tail > 0) checkOutput("idle after frame", badTail, 0);
    endtask

    initial begin
`ifdef SPI_CTRL_OVR_ERR_EN
        ovrEnabled = 1;
`else
        ovrEnabled = 0;
`endif
        //        sel  dat    inj  injDat rst tail expRx  done edges
        vecs[0] = '{4, 8'hA5,  0, 8'h00,  0,  4, 8'hA5, 69, 8};
        vecs[1] = '{4, 8'h3C,  0, 8'h00,  0,  0, 8'h3C, 69, 8};
        vecs[2] = '{4, 8'hC3,  0, 8'h00,  0,  4, 8'hC3, 69, 8};
        vecs[3] = '{4, 8'h12, 30, 8'hFF,  0, 20, 8'h12, 69, 8};
        vecs[4] = '{4, 8'h81,  0, 8'h00, 23,  4, 8'h00,  0, 3};
        vecs[5] = '{4, 8'h7E,  0, 8'h00,  0,  4, 8'h7E, 69, 8};
        vecs[6] = '{1, 8'hFF,  0, 8'h00,  0,  0, 8'hFF, 18, 8};
        vecs[7] = '{1, 8'h00,  0, 8'h00,  0,  4, 8'h00, 18, 8};

        #2 rst = 1'b1;
        #1;
        curSel = 4;
        #0;
        checkResetOutputs("reset x4");
        curSel = 1;
        #0;
        checkResetOutputs("reset x1");
        #17 rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < NV; n++) begin
            applyStimulus(vecs[n]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_ctrl_pos.md
# spi_ctrl_pos

SPI controller (master) that serialises one parallel byte per request onto `sclk`/`mosi`/`cs` for the downstream `spiperipos` peripheral receiver. It runs in SPI mode 0, MSB first, from the system clock, and divides that clock to generate `sclk`. It frames every byte with exactly 8 rising `sclk` edges inside a single `cs`-low window, which is what the receiver requires to deliver a clean byte.

## Interface
- `CLK_DIV`, 4: system clocks per `sclk` half-period; legal 1..255 (8-bit counter).
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `tx_dat` input 8: byte to send; sampled only when a request is accepted.
- `tx_start` input 1: request strobe, level-sampled each `clk`.
- `sclk` output 1: SPI clock, idle low, registered.
- `mosi` output 1: serial data, registered, changes only while `sclk` is low.
- `cs` output 1: chip select, active low, registered.
- `busy` output 1: high from acceptance until the cycle `cs` returns high.
- `done` output 1: one-cycle pulse at end of frame.
- `ovr_err` output 1: sticky overrun flag (see Configuration).

## Operation
- States: IDLE, SETUP, SCLK_HI, SCLK_LO, HOLD. A half-period counter `div_cnt` counts 0..CLK_DIV-1. A bit counter `bit_cnt` counts 0..7.
- IDLE: `cs`=1, `sclk`=0, `busy`=0. If `tx_start`=1, latch `tx_dat` into the shift register and go to SETUP. On that same edge: `cs`<=0, `mosi`<=`tx_dat[7]`, `busy`<=1.
- SETUP: hold `sclk` low for CLK_DIV cycles, then `sclk`<=1 and go to SCLK_HI.
- SCLK_HI: hold for CLK_DIV cycles, then `sclk`<=0.
  - If `bit_cnt`=7, go to HOLD.
  - Otherwise, shift left, drive the next bit on `mosi`, increment `bit_cnt`, and go to SCLK_LO.
- SCLK_LO: hold for CLK_DIV cycles, then `sclk`<=1 and go to SCLK_HI.
- HOLD: keep `cs` low for CLK_DIV cycles after the last falling edge. Then `cs`<=1, `busy`<=0, `done`<=1 for one cycle, `mosi`<=0, `bit_cnt`<=0, and return to IDLE.
- Framing: exactly 8 rising `sclk` edges per frame. Bits are sent MSB first, so the receiver's left shift reproduces `tx_dat`.
- `tx_start` while `busy`=1 is ignored. The frame in flight and its latched data are not affected.
- `tx_dat` changes after acceptance have no effect on the frame in flight.
- Reset, including mid-frame, asynchronously forces: IDLE, `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `ovr_err`=0, counters 0. A partial frame is abandoned; the receiver sees `cs` high and discards it.

## Timing
- Acceptance edge is cycle 0. `cs` falls and `mosi`=bit7 at cycle 1.
- Rising `sclk` edges occur at cycle 1+(2k+1)·CLK_DIV, for k=0..7.
- Falling `sclk` edges occur at cycle 1+(2k+2)·CLK_DIV; the next bit appears on `mosi` at each falling edge.
- `cs` rises, `busy` falls and `done` pulses at cycle 1+17·CLK_DIV.
- Example: CLK_DIV=4 gives `done` at cycle 69.
- `mosi` setup to each rising `sclk` is ≥ CLK_DIV system clocks; `mosi` hold after each rising edge is CLK_DIV clocks.
- Back-to-back frames: the earliest next acceptance is the cycle after `done`. The minimum `cs`-high gap is 1 cycle.

## Configuration
- `SPI_CTRL_OVR_ERR_EN` defined: `tx_start`=1 sampled while `busy`=1 sets `ovr_err`. The flag is sticky until `rst`. The dropped request has no other effect.
- `SPI_CTRL_OVR_ERR_EN` undefined: `ovr_err` is tied to 0 and no flag logic is built.

## Test plan
- Reset check: assert `rst` → `cs`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `ovr_err`=0, all immediately.
- Single frame: CLK_DIV=4, `tx_dat`=0xA5, one-cycle `tx_start` → 8 rising `sclk` edges; `done` at cycle 69; attached `spiperipos` `rcvd_p_dat`=0xA5 after the 8th edge.
- Back-to-back: send 0x3C, then assert `tx_start` with 0xC3 on the cycle after `done` → `cs` high for exactly 1 cycle between frames; receiver captures 0x3C, then 0xC3.
- Ignored request: pulse `tx_start` with `tx_dat`=0xFF mid-frame while sending 0x12 → receiver gets 0x12; no extra frame; `ovr_err`=1 only with the macro defined, else 0.
- Reset mid-frame: assert `rst` after the 3rd rising edge of 0x81 → `cs`=1 and `sclk`=0 at once. A following 0x7E frame is received as 0x7E.
- Fast divider: CLK_DIV=1, frames 0xFF then 0x00 → `done` at cycle 18 of each frame; receiver values 0xFF and 0x00.
